// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename/commit port bundle for the physical-register free list (FREE_LIST_CHECK_EN adds fl_error)
interface free_list_if #(
    parameter int PW = 6
);
    logic          rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3;
    logic          rename_stall;
    logic [PW-1:0] alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3;
    logic          free_list_stall;
    logic          cmt_en_0, cmt_en_1, cmt_en_2, cmt_en_3;
    logic [PW-1:0] cmt_pprd_0, cmt_pprd_1, cmt_pprd_2, cmt_pprd_3;
    logic          predict_fail;
`ifdef FREE_LIST_CHECK_EN
    logic          fl_error;

    modport master (
        output rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3, rename_stall,
        output cmt_en_0, cmt_en_1, cmt_en_2, cmt_en_3,
        output cmt_pprd_0, cmt_pprd_1, cmt_pprd_2, cmt_pprd_3, predict_fail,
        input  alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3,
        input  free_list_stall, fl_error
    );

    modport slave (
        input  rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3, rename_stall,
        input  cmt_en_0, cmt_en_1, cmt_en_2, cmt_en_3,
        input  cmt_pprd_0, cmt_pprd_1, cmt_pprd_2, cmt_pprd_3, predict_fail,
        output alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3,
        output free_list_stall, fl_error
    );
`else
    modport master (
        output rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3, rename_stall,
        output cmt_en_0, cmt_en_1, cmt_en_2, cmt_en_3,
        output cmt_pprd_0, cmt_pprd_1, cmt_pprd_2, cmt_pprd_3, predict_fail,
        input  alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3,
        input  free_list_stall
    );

    modport slave (
        input  rd_valid_0, rd_valid_1, rd_valid_2, rd_valid_3, rename_stall,
        input  cmt_en_0, cmt_en_1, cmt_en_2, cmt_en_3,
        input  cmt_pprd_0, cmt_pprd_1, cmt_pprd_2, cmt_pprd_3, predict_fail,
        output alloc_preg_0, alloc_preg_1, alloc_preg_2, alloc_preg_3,
        output free_list_stall
    );
`endif
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - 4-wide physical-register free list with speculative/arch heads (optional FREE_LIST_CHECK_EN overflow/underflow check)
module free_list #(
    parameter int NPREG = 64,
    parameter int PW    = 6,
    parameter int NWAY  = 4
) (
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave fl
);
    localparam int CW = $clog2(NWAY + 1);
    localparam int KW = PW + 1;

    logic [PW-1:0]   queue [NPREG];
    logic [PW-1:0]   head, arch_head, tail;
    logic [KW-1:0]   count, arch_count;

    logic [NWAY-1:0] rd_valid, cmt_en, eff_free;
    logic [PW-1:0]   cmt_pprd   [NWAY];
    logic [CW-1:0]   alloc_pos  [NWAY];
    logic [CW-1:0]   free_pos   [NWAY];
    logic [PW-1:0]   alloc_preg [NWAY];
    logic [CW-1:0]   n_alloc, n_free, n_cmt;
    logic            stall, fire;
    logic [PW-1:0]   arch_head_next;
    logic [KW-1:0]   arch_count_next, count_next;

    assign rd_valid    = {fl.rd_valid_3, fl.rd_valid_2, fl.rd_valid_1, fl.rd_valid_0};
    assign cmt_en      = {fl.cmt_en_3, fl.cmt_en_2, fl.cmt_en_1, fl.cmt_en_0};
    assign cmt_pprd[0] = fl.cmt_pprd_0;
    assign cmt_pprd[1] = fl.cmt_pprd_1;
    assign cmt_pprd[2] = fl.cmt_pprd_2;
    assign cmt_pprd[3] = fl.cmt_pprd_3;

    // Slot-order prefix counts: allocation offsets and compacted positions of real frees (preg 0 is never freed)
    always_comb begin
        n_alloc   = '0;
        n_free    = '0;
        n_cmt     = '0;
        eff_free  = '0;
        alloc_pos = '{default: '0};
        free_pos  = '{default: '0};
        for (int i = 0; i < NWAY; i++) begin
            alloc_pos[i] = n_alloc;
            free_pos[i]  = n_free;
            eff_free[i]  = cmt_en[i] && (cmt_pprd[i] != '0);
            n_alloc      = n_alloc + CW'(rd_valid[i]);
            n_free       = n_free + CW'(eff_free[i]);
            n_cmt        = n_cmt + CW'(cmt_en[i]);
        end
    end

    // Allocated pregs are read straight out of the queue at the speculative head
    always_comb begin
        alloc_preg = '{default: '0};
        for (int i = 0; i < NWAY; i++) begin
            alloc_preg[i] = queue[head + PW'(alloc_pos[i])];
        end
    end

    assign fl.alloc_preg_0 = alloc_preg[0];
    assign fl.alloc_preg_1 = alloc_preg[1];
    assign fl.alloc_preg_2 = alloc_preg[2];
    assign fl.alloc_preg_3 = alloc_preg[3];

    assign stall              = count < KW'(n_alloc);
    assign fl.free_list_stall = stall;
    assign fire               = (n_alloc != '0) && !fl.rename_stall && !stall && !fl.predict_fail;

    assign arch_head_next  = arch_head + PW'(n_cmt);
    assign arch_count_next = arch_count + KW'(n_free) - KW'(n_cmt);
    assign count_next      = count + KW'(n_free) - (fire ? KW'(n_alloc) : KW'(0));

    // Queue storage: identity contents at reset, released pregs appended at the tail
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NPREG; k++) begin
                queue[k] <= PW'(k);
            end
        end else begin
            for (int i = 0; i < NWAY; i++) begin
                if (eff_free[i]) begin
                    queue[tail + PW'(free_pos[i])] <= cmt_pprd[i];
                end
            end
        end
    end

    // Pointers and occupancy; a flush snaps the speculative view onto the post-commit arch view
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= PW'(1);
            arch_head  <= PW'(1);
            tail       <= '0;
            count      <= KW'(NPREG - 1);
            arch_count <= KW'(NPREG - 1);
        end else begin
            tail       <= tail + PW'(n_free);
            arch_head  <= arch_head_next;
            arch_count <= arch_count_next;
            if (fl.predict_fail) begin
                head  <= arch_head_next;
                count <= arch_count_next;
            end else begin
                if (fire) begin
                    head <= head + PW'(n_alloc);
                end
                count <= count_next;
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    localparam int EW = KW + 1;

    logic overflow, underflow, fl_error_q;

    assign overflow  = (EW'(count) + EW'(n_free)) > EW'(NPREG - 1);
    assign underflow = fire && (count < KW'(n_alloc));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fl_error_q <= 1'b0;
        end else if (overflow || underflow) begin
            fl_error_q <= 1'b1;
        end
    end

    assign fl.fl_error = fl_error_q;

    a_no_overflow:  assert property (@(posedge clock) disable iff (!reset) !overflow);
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset) !underflow);
`endif
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list
module tb_free_list;
    localparam int NPREG = 64;
    localparam int PW    = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;

    free_list_if #(.PW(PW)) fl ();

    free_list #(.NPREG(NPREG), .PW(PW), .NWAY(4)) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int free_q[$];
    int hist_q[$];
    int exp_q[$];
    int spec_used;
    int arch_head_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alloc_out(input int i);
        case (i)
            0:       return 32'(fl.alloc_preg_0);
            1:       return 32'(fl.alloc_preg_1);
            2:       return 32'(fl.alloc_preg_2);
            default: return 32'(fl.alloc_preg_3);
        endcase
    endfunction

    task automatic drive(input logic [3:0] rv, input logic rs, input logic [3:0] ce,
                         input int p0, input int p1, input int p2, input int p3, input logic pf);
        fl.rd_valid_0 = rv[0]; fl.rd_valid_1 = rv[1]; fl.rd_valid_2 = rv[2]; fl.rd_valid_3 = rv[3];
        fl.rename_stall = rs;
        fl.cmt_en_0 = ce[0]; fl.cmt_en_1 = ce[1]; fl.cmt_en_2 = ce[2]; fl.cmt_en_3 = ce[3];
        fl.cmt_pprd_0 = PW'(p0); fl.cmt_pprd_1 = PW'(p1); fl.cmt_pprd_2 = PW'(p2); fl.cmt_pprd_3 = PW'(p3);
        fl.predict_fail = pf;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(dut.count), 32'(free_q.size() - spec_used));
        check({tag, "_head"}, 32'(dut.head), 32'((arch_head_m + spec_used) % NPREG));
    endtask

    task automatic step(input logic [3:0] rv, input logic rs, input logic [3:0] ce,
                        input int p0, input int p1, input int p2, input int p3, input logic pf);
        int   pp[4];
        int   n, k, ncmt, avail, tmp;
        logic exp_stall, fire;
        pp = '{p0, p1, p2, p3};
        drive(rv, rs, ce, p0, p1, p2, p3, pf);
        n         = $countones(rv);
        avail     = free_q.size() - spec_used;
        exp_stall = avail < n;
        if (!exp_stall) begin
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    exp_q.push_back(free_q[spec_used + k]);
                    k++;
                end
            end
        end
        @(negedge clock);
        check("stall", 32'(fl.free_list_stall), 32'(exp_stall));
        if (!exp_stall) begin
            for (int i = 0; i < 4; i++) begin
                if (rv[i]) begin
                    check($sformatf("alloc_%0d", i), alloc_out(i), 32'(exp_q.pop_front()));
                end
            end
        end
        fire = (n > 0) && !rs && !exp_stall && !pf;
        @(posedge clock);
        if (fire) begin
            for (int j = 0; j < n; j++) hist_q.push_back(free_q[spec_used + j]);
            spec_used += n;
        end
        ncmt = $countones(ce);
        for (int j = 0; j < ncmt; j++) tmp = free_q.pop_front();
        spec_used  -= ncmt;
        arch_head_m = (arch_head_m + ncmt) % NPREG;
        for (int i = 0; i < 4; i++) begin
            if (ce[i] && pp[i] != 0) free_q.push_back(pp[i]);
        end
        if (pf) spec_used = 0;
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        free_q = {};
        for (int k = 1; k < NPREG; k++) free_q.push_back(k);
        hist_q      = {};
        exp_q       = {};
        spec_used   = 0;
        arch_head_m = 1;
        @(negedge clock);
        check("rst_alloc0", 32'(fl.alloc_preg_0), 32'd1);
        check("rst_stall", 32'(fl.free_list_stall), 32'd0);
        check("rst_count", 32'(dut.count), 32'(NPREG - 1));
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a, b, c, d;

        do_reset();
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0);
        check_state("after5");
        check("count58", 32'(dut.count), 32'd58);
        step(4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0);
        check_state("rstall");

        do_reset();
        step(4'b1010, 0, 4'b0000, 0, 0, 0, 0, 0);
        check_state("sparse");

        do_reset();
        for (int i = 0; i < 15; i++) step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        check_state("nearly_empty");
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        check_state("stalled");
        step(4'b1111, 0, 4'b0001, 7, 0, 0, 0, 0);
        check_state("stall_free");
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        check_state("unstalled");

        do_reset();
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 4'b0011, 9, 0, 0, 0, 0);
        check_state("pre_flush");
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 1);
        check_state("flush");
        check("flush_head3", 32'(dut.head), 32'd3);
        check("flush_count", 32'(dut.count), 32'(NPREG - 2));
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        check_state("post_flush");

        do_reset();
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        step(4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            a = hist_q.pop_front();
            b = hist_q.pop_front();
            c = hist_q.pop_front();
            d = hist_q.pop_front();
            step(4'b1111, 0, 4'b1111, a, b, c, d, 0);
            check_state("wrap");
        end
        check("wrap_count", 32'(dut.count), 32'd55);

`ifdef FREE_LIST_CHECK_EN
        do_reset();
        check("err_rst", 32'(fl.fl_error), 32'd0);
        step(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 0);
        check("err_pre", 32'(fl.fl_error), 32'd0);
        drive(4'b0000, 0, 4'b1111, 10, 11, 12, 13, 0);
        @(posedge clock);
        #1;
        drive(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("err_set", 32'(fl.fl_error), 32'd1);
        @(posedge clock);
        @(negedge clock);
        check("err_sticky", 32'(fl.fl_error), 32'd1);
        do_reset();
        check("err_clr", 32'(fl.fl_error), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list feeding the rename stage: supplies up to 4 newly allocated pregs per cycle as alloc_preg_0..3 for the CAM rename table.
- At commit, reclaims the previous mapping (pprd) of each retiring instruction.
- Circular queue with a speculative head, a committed (arch) head and a tail. On predict_fail the speculative head snaps back to the arch head in one cycle.

Parameters:
- NPREG, 64, number of physical registers; queue depth, power of 2.
- PW, 6, preg index width, log2(NPREG).
- NWAY, 4, rename and commit width (fixed at 4).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_valid_0..3  input  1 each  rename slot i writes a destination.
- rename_stall  input  1  rename group held this cycle; no allocation.
- alloc_preg_0..3  output  PW each  preg assigned to slot i; combinational from state.
- free_list_stall  output  1  fewer free entries than popcount(rd_valid_0..3).
- cmt_en_0..3  input  1 each  committing instruction i has a destination.
- cmt_pprd_0..3  input  PW each  old preg released by commit slot i.
- predict_fail  input  1  flush; recover speculative head.

Behaviour:
- State:
  - queue[NPREG] of PW bits.
  - head, arch_head, tail: PW-bit pointers, wrap modulo NPREG.
  - count, arch_count: PW+1 bits.
- Reset (async, reset==0):
  - queue[k]=k for k=1..NPREG-1; queue[0]=0 (unused).
  - head=arch_head=1; tail=0 (wraps, so the next free is written at 0).
  - count=arch_count=NPREG-1.
  - Outputs after reset: alloc_preg_i = queue[head + prefix_i], so alloc_preg_0=1 with prefix 0. free_list_stall=0.
- Preg 0 is the default mapping of every arch reg at reset. It is never allocated and never freed: cmt_en_i with cmt_pprd_i==0 is ignored.
- Allocation:
  - prefix_i = popcount(rd_valid_0..rd_valid_{i-1}).
  - alloc_preg_i = queue[(head+prefix_i) mod NPREG], valid only when rd_valid_i.
  - n_alloc = popcount(rd_valid); fires when n_alloc>0, !rename_stall, !free_list_stall and !predict_fail.
  - On fire, head += n_alloc. Zero-cycle latency: alloc_preg is valid in the same cycle as rd_valid.
- Commit:
  - Effective frees are the cmt_en_i with cmt_pprd_i!=0, compacted in slot order.
  - Write queue[tail+j]=pprd of the j-th effective free; tail += n_free.
  - arch_head += n_cmt, where n_cmt = popcount(cmt_en) for slots whose commit consumed an allocation.
  - arch_count += n_free - n_cmt.
- count_next = count + n_free - (fire ? n_alloc : 0). Alloc and free in the same cycle are both applied. Tail writes never overlap live entries because count <= NPREG-1.
- predict_fail:
  - Commits in the same cycle still apply.
  - head <= arch_head_next; count <= arch_count_next; no allocation.
  - free_list_stall is ignored by the consumer during a flush.
- free_list_stall = (count < n_alloc). It is purely combinational from count and rd_valid.
- Wrap-around: all pointer arithmetic is modulo NPREG. Allocation and commit groups may straddle index NPREG-1 to 0.
- Full: count==NPREG-1 with n_free>0 is illegal (double free); queue behaviour is undefined unless the optional check is enabled.
- Reset mid-operation: all state returns to the reset values immediately, regardless of in-flight alloc or commit.

Optional Feature:
- Macro: FREE_LIST_CHECK_EN.
- When defined:
  - Adds output fl_error (1 bit, reset 0).
  - fl_error is sticky-set on an overflow free (count + n_free > NPREG-1) or an underflow allocation (fire with count < n_alloc).
  - Adds simulation assertions for the same two conditions.
- When undefined: no extra port, logic or assertions.

Test Plan:
- Reset release, rd_valid=1111, no stall -> alloc_preg=1,2,3,4; next cycle alloc_preg_0=5; count=58.
- rd_valid=1010 -> alloc_preg_1=1, alloc_preg_3=2; head advances by 2.
- Allocate 60 pregs (count=3), then rd_valid=1111 -> free_list_stall=1, head unchanged. Commit cmt_en=0001 pprd=7 -> stall drops next cycle.
- Allocate 8, commit 2 (cmt_pprd=9,0), then assert predict_fail -> head=arch_head=3, count=arch_count=NPREG-2, preg 0 not enqueued.
- Run head/tail across index 63 to 0 with 4-wide alloc and 4-wide commit in the same cycle -> allocated sequence is continuous and count is unchanged.
- With FREE_LIST_CHECK_EN, free 4 pregs when count=62 -> fl_error=1 next cycle and stays set until reset.
